// File: rtl/imem_pkg.sv
// Shared definitions for the instruction memory fetch block.
// IMEM_PARITY_EN widens the array to 33 bits and enables the parity check on read.
package imem_pkg;

   localparam logic [1:0]  FLT_OK       = 2'b00;
   localparam logic [1:0]  FLT_MISALIGN = 2'b01;
   localparam logic [1:0]  FLT_RANGE    = 2'b10;
   localparam logic [1:0]  FLT_PARITY   = 2'b11;

   localparam logic [31:0] NOP_INST     = 32'h0000_0013;

`ifdef IMEM_PARITY_EN
   localparam int ARR_W = 33;
`else
   localparam int ARR_W = 32;
`endif

   // One response slot (output register or skid register).
   // from_arr marks a slot whose instruction still sits in the array read
   // register; it is copied into inst on the next edge.
   typedef struct packed {
      logic        valid;
      logic        from_arr;
      logic [31:0] pc;
      logic [31:0] inst;
      logic [1:0]  fault;
   } slot_t;

endpackage

// File: rtl/imem_array.sv
// DEPTH x W RAM: synchronous write, registered read with read enable.
// Kept separate so it can be replaced by a vendor memory macro.
module imem_array #(
   parameter int DEPTH = 256,
   parameter int AW    = $clog2(DEPTH),
   parameter int W     = 32
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [W-1:0]  wr_data,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   output logic [W-1:0]  rd_data
);

   logic [W-1:0] mem_q [DEPTH];
   logic [W-1:0] rd_data_q;

   // Write port and registered read port; contents survive reset.
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_addr] <= wr_data;
      if (rd_en) rd_data_q <= mem_q[rd_addr];
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/imem_fetch.sv
// Instruction memory with a valid/ready fetch port, one-entry skid buffer,
// fault reporting and a program-load write port.
// Define IMEM_PARITY_EN to store an even-parity bit per word and report
// parity faults on read.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; valid never depends on ready, and a presented response holds
// pc/inst/fault stable until it is taken.
module imem_fetch #(
   parameter int          DEPTH    = 256,
   parameter logic [31:0] NOP_INST = imem_pkg::NOP_INST
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [31:0]              req_pc,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [31:0]              rsp_inst,
   output logic [31:0]              rsp_pc,
   output logic [1:0]               rsp_fault,
   input  logic                     flush,
   input  logic                     ld_valid,
   input  logic [$clog2(DEPTH)-1:0] ld_addr,
   input  logic [31:0]              ld_data
);

   import imem_pkg::*;

   localparam int AW = $clog2(DEPTH);
   localparam slot_t EMPTY_SLOT = '{valid: 1'b0, from_arr: 1'b0, pc: 32'd0,
                                    inst: NOP_INST, fault: FLT_OK};

   slot_t            out_q, out_d, skid_q, skid_d;
   slot_t            out_view, skid_view, new_slot;
   logic             accept, stalled;
   logic             rd_en;
   logic [ARR_W-1:0] arr_wdata, arr_rdata;

   // Resolve a slot whose data is still in the array read register.
   function automatic slot_t settle(input slot_t s, input logic [ARR_W-1:0] rd);
      slot_t r;
      r = s;
      if (s.from_arr) begin
         r.from_arr = 1'b0;
         r.inst     = rd[31:0];
`ifdef IMEM_PARITY_EN
         if (^rd) begin
            r.inst  = NOP_INST;
            r.fault = FLT_PARITY;
         end
`endif
      end
      return r;
   endfunction

`ifdef IMEM_PARITY_EN
   assign arr_wdata = {^ld_data, ld_data};
`else
   assign arr_wdata = ld_data;
`endif

   imem_array #(.DEPTH(DEPTH), .AW(AW), .W(ARR_W)) u_array (
      .clk     (clk),
      .wr_en   (ld_valid),
      .wr_addr (ld_addr),
      .wr_data (arr_wdata),
      .rd_en   (rd_en),
      .rd_addr (req_pc[AW+1:2]),
      .rd_data (arr_rdata)
   );

   assign req_ready = reset && !skid_q.valid && !ld_valid && !flush;
   assign accept    = req_valid && req_ready;
   assign stalled   = out_q.valid && !rsp_ready;

   assign out_view  = settle(out_q, arr_rdata);
   assign skid_view = settle(skid_q, arr_rdata);

   assign rsp_valid = out_q.valid;
   assign rsp_inst  = out_view.inst;
   assign rsp_pc    = out_view.pc;
   assign rsp_fault = out_view.fault;

   // Classify the incoming request; faulted requests skip the array read.
   always_comb begin
      new_slot       = EMPTY_SLOT;
      new_slot.valid = 1'b1;
      new_slot.pc    = req_pc;
      if (req_pc[1:0] != 2'b00)             new_slot.fault = FLT_MISALIGN;
      else if (req_pc[31:AW+2] != '0)       new_slot.fault = FLT_RANGE;
      else                                  new_slot.fault = FLT_OK;
      new_slot.from_arr = (new_slot.fault == FLT_OK);
      rd_en = accept && new_slot.from_arr;
   end

   // Next state of the output and skid registers.
   always_comb begin
      out_d  = out_view;
      skid_d = skid_view;
      if (flush) begin
         out_d  = EMPTY_SLOT;
         skid_d = EMPTY_SLOT;
      end else if (stalled) begin
         if (!skid_q.valid && accept) skid_d = new_slot;
      end else if (skid_q.valid) begin
         out_d  = skid_view;
         skid_d = accept ? new_slot : EMPTY_SLOT;
      end else begin
         out_d  = accept ? new_slot : EMPTY_SLOT;
         skid_d = EMPTY_SLOT;
      end
   end

   // Response registers; reset drops everything pending.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_q  <= EMPTY_SLOT;
         skid_q <= EMPTY_SLOT;
      end else begin
         out_q  <= out_d;
         skid_q <= skid_d;
      end
   end

endmodule
